writeback_arbiter: RTL and testbench

Shares the register file's single write port among several writeback sources: ALU, load unit and CSR/mul-div. Each source presents a request with a valid/ready handshake. The block grants one legal write per cycle, round-robin by default, and registers the winner onto the register file's `writeEnable`/`desRegister`/`writeData` inputs. Writes to x0 are absorbed without using a port slot. A saturating counter records contention cycles.

---
 rtl/writeback_arbiter_pkg.sv | 23 ++
 rtl/writeback_arbiter_picker.sv | 37 +++
 rtl/writeback_arbiter.sv | 96 +++++++++
 tb/tb_writeback_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback constants (source ids, widths) and a popcount helper for the
// register-file write-port arbiter.
package writeback_arbiter_pkg;

  localparam int DATA_WIDTH_32  = 32;
  localparam int REGISTER_NUM   = 32;
  localparam int WB_NUM_SOURCES = 3;

  localparam int WB_SRC_ALU  = 0;
  localparam int WB_SRC_LOAD = 1;
  localparam int WB_SRC_CSR  = 2;

  // Up to eight sources are supported, so callers zero-extend their mask to 8 bits.
  function automatic int countOnes(input logic [7:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/writeback_arbiter_picker.sv
// rr_priority_picker: combinational pick of the first set mask bit at or after ptr,
// wrapping; returns a one-hot grant and its encoded index.
module rr_priority_picker
  import writeback_arbiter_pkg::*;
#(
  parameter int N     = WB_NUM_SOURCES,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grantIdx,
  output logic             anyGrant
);

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    anyGrant = 1'b0;
    // First pass covers indices at or after ptr; the second wraps to the low ones.
    for (int i = 0; i < N; i++) begin
      if (!anyGrant && mask[i] && (i >= int'(ptr))) begin
        anyGrant = 1'b1;
        grant[i] = 1'b1;
        grantIdx = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!anyGrant && mask[i]) begin
        anyGrant = 1'b1;
        grant[i] = 1'b1;
        grantIdx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: x0 writes are absorbed, one legal write per cycle
// is registered out. WB_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int  NUM_REQ    = WB_NUM_SOURCES,
  parameter int  DATA_WIDTH = DATA_WIDTH_32,
  parameter int  ADDR_WIDTH = 5,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              reqValid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   reqAddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   reqData,
  output logic [NUM_REQ-1:0]              reqReady,
  output logic                            writeEnable,
  output logic [ADDR_WIDTH-1:0]           desRegister,
  output logic [DATA_WIDTH-1:0]           writeData,
  output logic [IDX_W-1:0]                grantId,
  output logic [15:0]                     conflictCount
);

  // Handshake: source i transfers when reqValid[i] && reqReady[i]; it holds valid,
  // addr and data until then. reqReady is a function of all requests and the
  // pointer, never of a source dropping its own valid.
  logic [ADDR_WIDTH-1:0] srcAddr [NUM_REQ];
  logic [DATA_WIDTH-1:0] srcData [NUM_REQ];
  logic [NUM_REQ-1:0]    zeroMask;
  logic [NUM_REQ-1:0]    compMask;
  logic [NUM_REQ-1:0]    grantOneHot;
  logic [IDX_W-1:0]      grantIdx;
  logic [IDX_W-1:0]      pickPtr;
  logic                  anyGrant;
  logic                  multiReq;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign srcAddr[g]  = reqAddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign srcData[g]  = reqData[g*DATA_WIDTH +: DATA_WIDTH];
    assign zeroMask[g] = reqValid[g] && (srcAddr[g] == '0);
    assign compMask[g] = reqValid[g] && (srcAddr[g] != '0);
  end

  assign multiReq = countOnes(8'(compMask)) >= 2;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rrPtr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr <= '0;
    end else if (anyGrant) begin
      rrPtr <= (grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdx + IDX_W'(1);
    end
  end

  assign pickPtr = rrPtr;
`else
  assign pickPtr = '0;
`endif

  rr_priority_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .mask     (compMask),
    .ptr      (pickPtr),
    .grant    (grantOneHot),
    .grantIdx (grantIdx),
    .anyGrant (anyGrant)
  );

  // x0 writes complete immediately and never occupy the write port.
  assign reqReady = reset ? '0 : (zeroMask | grantOneHot);

  always_ff @(posedge clk) begin
    if (reset) begin
      writeEnable   <= 1'b0;
      desRegister   <= '0;
      writeData     <= '0;
      grantId       <= '0;
      conflictCount <= '0;
    end else begin
      writeEnable <= anyGrant;
      if (anyGrant) begin
        desRegister <= srcAddr[grantIdx];
        writeData   <= srcData[grantIdx];
        grantId     <= grantIdx;
      end
      if (multiReq && (conflictCount != 16'hFFFF)) begin
        conflictCount <= conflictCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int QW      = IDX_W + AW + DW;

  logic                    clk;
  logic                    reset;
  logic [NUM_REQ-1:0]      reqValid;
  logic [NUM_REQ*AW-1:0]   reqAddr;
  logic [NUM_REQ*DW-1:0]   reqData;
  logic [NUM_REQ-1:0]      reqReady;
  logic                    writeEnable;
  logic [AW-1:0]           desRegister;
  logic [DW-1:0]           writeData;
  logic [IDX_W-1:0]        grantId;
  logic [15:0]             conflictCount;

  int tests = 0;
  int fails = 0;

  logic          vA [NUM_REQ];
  logic [AW-1:0] aA [NUM_REQ];
  logic [DW-1:0] dA [NUM_REQ];

  writeback_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .reqValid      (reqValid),
    .reqAddr       (reqAddr),
    .reqData       (reqData),
    .reqReady      (reqReady),
    .writeEnable   (writeEnable),
    .desRegister   (desRegister),
    .writeData     (writeData),
    .grantId       (grantId),
    .conflictCount (conflictCount)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NUM_REQ; i++) begin
      reqValid[i]             = vA[i];
      reqAddr[i*AW +: AW]     = aA[i];
      reqData[i*DW +: DW]     = dA[i];
    end
  endtask

  task automatic setSrc(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    vA[i] = v;
    aA[i] = a;
    dA[i] = d;
  endtask

  task automatic clearAll();
    for (int i = 0; i < NUM_REQ; i++) setSrc(i, 1'b0, '0, '0);
    apply();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    clearAll();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [QW-1:0] exp_q[$];
  logic          mWe = 1'b0;
  int            mCount = 0;
  int            mPtr = 0;

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] expReady;
    logic [QW-1:0]      e;
    int comp;
    int win;
    int start;
    int j;

    check("writeEnable", 64'(writeEnable), 64'(mWe));
    check("conflictCount", 64'(conflictCount), 64'(mCount));
    if (writeEnable === 1'b1 && mWe) begin
      if (exp_q.size() == 0) begin
        check("beatQueueEmpty", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("beat", 64'({grantId, desRegister, writeData}), 64'(e));
      end
    end

    expReady = '0;
    comp = 0;
    win = -1;
`ifdef WB_ARB_ROUND_ROBIN_EN
    start = mPtr;
`else
    start = 0;
`endif
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (reqValid[i] && reqAddr[i*AW +: AW] != '0) comp++;
        else if (reqValid[i]) expReady[i] = 1'b1;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (start + k) % NUM_REQ;
        if (win < 0 && reqValid[j] && reqAddr[j*AW +: AW] != '0) win = j;
      end
      if (win >= 0) expReady[win] = 1'b1;
    end
    check("reqReady", 64'(reqReady), 64'(expReady));

    if (reset) begin
      mWe = 1'b0;
      mCount = 0;
      mPtr = 0;
      exp_q.delete();
    end else begin
      mWe = (win >= 0);
      if (win >= 0) begin
        exp_q.push_back({IDX_W'(win), reqAddr[win*AW +: AW], reqData[win*DW +: DW]});
        mPtr = (win + 1) % NUM_REQ;
      end
      if (comp >= 2 && mCount < 65535) mCount++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NUM_REQ-1:0] acc;
    reset = 1'b1;
    clearAll();
    // x0 request during reset must not be acknowledged
    setSrc(1, 1'b1, 5'd0, 32'h1111);
    apply();
    @(negedge clk);
    check("resetReadyX0", 64'(reqReady), 64'(3'b000));
    tick();
    clearAll();
    tick();
    reset = 1'b0;
    check("resetWe", 64'(writeEnable), 64'(0));
    check("resetDes", 64'(desRegister), 64'(0));
    check("resetData", 64'(writeData), 64'(0));
    check("resetGrant", 64'(grantId), 64'(0));
    check("resetCount", 64'(conflictCount), 64'(0));

    // single ALU write of x5
    setSrc(0, 1'b1, 5'd5, 32'hDEADBEEF);
    apply();
    @(negedge clk);
    check("t1Ready", 64'(reqReady), 64'(3'b001));
    tick();
    clearAll();
    check("t1We", 64'(writeEnable), 64'(1));
    check("t1Des", 64'(desRegister), 64'(5));
    check("t1Data", 64'(writeData), 64'(32'hDEADBEEF));
    check("t1Grant", 64'(grantId), 64'(0));

`ifdef WB_ARB_ROUND_ROBIN_EN
    // all three sources, each holding until served
    pulseReset();
    setSrc(0, 1'b1, 5'd1, 32'hA);
    setSrc(1, 1'b1, 5'd2, 32'hB);
    setSrc(2, 1'b1, 5'd3, 32'hC);
    apply();
    @(negedge clk);
    check("t2Ready0", 64'(reqReady), 64'(3'b001));
    tick();
    setSrc(0, 1'b0, '0, '0);
    apply();
    check("t2Grant0", 64'(grantId), 64'(0));
    @(negedge clk);
    check("t2Ready1", 64'(reqReady), 64'(3'b010));
    tick();
    setSrc(1, 1'b0, '0, '0);
    apply();
    check("t2Grant1", 64'(grantId), 64'(1));
    @(negedge clk);
    check("t2Ready2", 64'(reqReady), 64'(3'b100));
    tick();
    clearAll();
    check("t2Grant2", 64'(grantId), 64'(2));
    check("t2Data2", 64'(writeData), 64'(32'hC));
    check("t2Count", 64'(conflictCount), 64'(2));
`else
    // fixed priority: source 0 keeps winning, source 2 stalls
    pulseReset();
    setSrc(2, 1'b1, 5'd6, 32'h66);
    for (int c = 0; c < 4; c++) begin
      setSrc(0, 1'b1, 5'd4, 32'h40 + 32'(c));
      apply();
      @(negedge clk);
      check("t4Ready", 64'(reqReady), 64'(3'b001));
      tick();
      check("t4Grant", 64'(grantId), 64'(0));
      check("t4Data", 64'(writeData), 64'(32'h40 + 32'(c)));
    end
    clearAll();
    check("t4Count", 64'(conflictCount), 64'(4));
`endif

    // x0 from load unit alongside ALU x3
    pulseReset();
    setSrc(0, 1'b1, 5'd3, 32'h33);
    setSrc(1, 1'b1, 5'd0, 32'h11);
    apply();
    @(negedge clk);
    check("t3Ready", 64'(reqReady), 64'(3'b011));
    tick();
    setSrc(0, 1'b1, 5'd1, 32'h01);
    setSrc(1, 1'b0, '0, '0);
    setSrc(2, 1'b1, 5'd2, 32'h02);
    apply();
    check("t3We", 64'(writeEnable), 64'(1));
    check("t3Des", 64'(desRegister), 64'(3));
    check("t3Count", 64'(conflictCount), 64'(0));
    @(negedge clk);
`ifdef WB_ARB_ROUND_ROBIN_EN
    check("t3PtrMoved", 64'(reqReady), 64'(3'b100));
`else
    check("t3Fixed", 64'(reqReady), 64'(3'b001));
`endif
    tick();
    clearAll();

    // reset right after a grant of x7
    pulseReset();
    setSrc(1, 1'b1, 5'd7, 32'h77);
    setSrc(2, 1'b1, 5'd9, 32'h99);
    apply();
    @(negedge clk);
    check("t5Ready", 64'(reqReady), 64'(3'b010));
    tick();
    reset = 1'b1;
    setSrc(0, 1'b1, 5'd4, 32'h44);
    setSrc(1, 1'b0, '0, '0);
    apply();
    check("t5We", 64'(writeEnable), 64'(1));
    check("t5Des", 64'(desRegister), 64'(7));
    check("t5Count", 64'(conflictCount), 64'(1));
    @(negedge clk);
    check("t5ReadyRst", 64'(reqReady), 64'(3'b000));
    tick();
    reset = 1'b0;
    check("t5WeDropped", 64'(writeEnable), 64'(0));
    check("t5CountClr", 64'(conflictCount), 64'(0));
    @(negedge clk);
    check("t5Restart", 64'(reqReady), 64'(3'b001));
    tick();
    clearAll();

    // random traffic, each source holds its request until accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = reqValid & reqReady;
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!vA[i] || acc[i]) begin
          vA[i] = ($urandom_range(0, 9) < 6);
          aA[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
          dA[i] = $urandom;
        end
      end
      apply();
    end
    reset = 1'b0;
    clearAll();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
